// File: rtl/clock_clk.sv
// Time-of-day clock: prescaler to a 1 Hz tick feeding cascaded sec/min/hour counters plus heartbeat LED.
// Latency: all outputs update on the same edge the prescaler wraps; carries ripple within that edge.
// Backpressure: none; free-running whenever rst is high, no stall or enable inputs.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   sec  - seconds 0..59
//   min  - minutes 0..59
//   hour - hours 0..23 (default) or 1..12 when CLOCK_CLK_12H_EN is defined
//   led  - heartbeat, inverts on every seconds tick
//
// Build option: define CLOCK_CLK_12H_EN for 12-hour display (12,1,..,11), reset value 12.
module clock_clk #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       led
);

  localparam int             DW      = $clog2(CLK_FREQ);
  localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_FREQ - 1);

`ifdef CLOCK_CLK_12H_EN
  localparam logic [4:0] HOUR_RST = 5'd12;
`else
  localparam logic [4:0] HOUR_RST = 5'd0;
`endif

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          sec_wrap;
  logic          min_wrap;
  logic [4:0]    hour_next;

  assign tick = (div_cnt == DIV_MAX);

  // >= rather than == so a corrupted counter still wraps on its next increment.
  assign sec_wrap = (sec >= 6'd59);
  assign min_wrap = (min >= 6'd59);

`ifdef CLOCK_CLK_12H_EN
  // 12 is the top of the cycle; 0 or out-of-range values fall through to 1.
  assign hour_next = (hour >= 5'd12) ? 5'd1 : hour + 5'd1;
`else
  assign hour_next = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      sec     <= 6'd0;
      min     <= 6'd0;
      hour    <= HOUR_RST;
      led     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        led <= ~led;
        sec <= sec_wrap ? 6'd0 : sec + 6'd1;
        // Carries are decoded from current values so a full rollover lands on one edge.
        if (sec_wrap) begin
          min <= min_wrap ? 6'd0 : min + 6'd1;
          if (min_wrap) begin
            hour <= hour_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_clk.sv
module tb_clock_clk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, rst2, rst8;
  logic [5:0] sec4, min4, sec2, min2, sec8, min8;
  logic [4:0] hour4, hour2, hour8;
  logic       led4, led2, led8;

  clock_clk #(.CLK_FREQ(4)) dut4 (.clk(clk), .rst(rst4), .sec(sec4), .min(min4), .hour(hour4), .led(led4));
  clock_clk #(.CLK_FREQ(2)) dut2 (.clk(clk), .rst(rst2), .sec(sec2), .min(min2), .hour(hour2), .led(led2));
  clock_clk #(.CLK_FREQ(8)) dut8 (.clk(clk), .rst(rst8), .sec(sec8), .min(min8), .hour(hour8), .led(led8));

`ifdef CLOCK_CLK_12H_EN
  localparam int H_RST  = 12;
  localparam int H_LAST = 11;
  localparam int H_WRAP = 12;
  localparam int H_BAD  = 14;
  localparam int H_BADN = 1;
  localparam int H_MAX  = 12;
`else
  localparam int H_RST  = 0;
  localparam int H_LAST = 23;
  localparam int H_WRAP = 0;
  localparam int H_BAD  = 26;
  localparam int H_BADN = 0;
  localparam int H_MAX  = 23;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int edges;
    int s;
    int m;
    int h;
    int l;
  } vec_t;

  vec_t tbl[7];

  // Reference: elapsed whole seconds -> wall-clock fields.
  function automatic void exp_time(input int t, output int s, output int m, output int h, output int l);
    int hh;
    s = t % 60;
    m = (t / 60) % 60;
`ifdef CLOCK_CLK_12H_EN
    hh = (t / 3600) % 12;
    h  = (hh == 0) ? 12 : hh;
`else
    hh = (t / 3600) % 24;
    h  = hh;
`endif
    l = t % 2;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input integer gs, input integer gm, input integer gh, input integer gl,
                       input integer es, input integer em, input integer eh, input integer el);
    checks++;
    if (gs !== es || gm !== em || gh !== eh || gl !== el) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d led=%0d, expected %0d:%0d:%0d led=%0d",
               name, gh, gm, gs, gl, eh, em, es, el);
    end
  endtask

  task automatic check_val(input string name, input integer got, input integer exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int cur;
    int n;
    int es, em, eh, el;

    tbl[0] = '{edges: 0,   s: 0,  m: 0, h: H_RST, l: 0};
    tbl[1] = '{edges: 3,   s: 0,  m: 0, h: H_RST, l: 0};
    tbl[2] = '{edges: 4,   s: 1,  m: 0, h: H_RST, l: 1};
    tbl[3] = '{edges: 7,   s: 1,  m: 0, h: H_RST, l: 1};
    tbl[4] = '{edges: 8,   s: 2,  m: 0, h: H_RST, l: 0};
    tbl[5] = '{edges: 239, s: 59, m: 0, h: H_RST, l: 1};
    tbl[6] = '{edges: 240, s: 0,  m: 1, h: H_RST, l: 0};

    // Reset held for 5 cycles on every instance.
    rst4 = 1'b0;
    rst2 = 1'b0;
    rst8 = 1'b0;
    step(5);
    check("reset_f4", sec4, min4, hour4, led4, 0, 0, H_RST, 0);
    check("reset_f2", sec2, min2, hour2, led2, 0, 0, H_RST, 0);
    check("reset_f8", sec8, min8, hour8, led8, 0, 0, H_RST, 0);

    // Table: edges after release on CLK_FREQ=4.
    rst4 = 1'b1;
    cur  = 0;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].edges - cur);
      cur = tbl[i].edges;
      check($sformatf("tbl_f4_edge%0d", tbl[i].edges), sec4, min4, hour4, led4,
            tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].l);
    end

    // Minute carry on CLK_FREQ=2: 59 ticks, then the 60th carries on one edge.
    rst2 = 1'b1;
    step(118);
    check("min_carry_pre", sec2, min2, hour2, led2, 59, 0, H_RST, 1);
    step(1);
    check("min_carry_hold", sec2, min2, hour2, led2, 59, 0, H_RST, 1);
    step(1);
    check("min_carry", sec2, min2, hour2, led2, 0, 1, H_RST, 0);

    // Day (or half-day) rollover: preload the last second, prescaler is at 0.
    force dut2.sec  = 6'd59;
    force dut2.min  = 6'd59;
    force dut2.hour = 5'(H_LAST);
    #1;
    release dut2.sec;
    release dut2.min;
    release dut2.hour;
    step(1);
    check("rollover_pre", sec2, min2, hour2, led2, 59, 59, H_LAST, 0);
    step(1);
    check("rollover", sec2, min2, hour2, led2, 0, 0, H_WRAP, 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (int'(hour2) > H_MAX) begin
        errors++;
        $display("FAIL hour_range: got %0d, limit %0d", hour2, H_MAX);
      end
    end

    // Out-of-range seconds wrap to 0 on the next tick.
    force dut2.sec  = 6'd62;
    force dut2.min  = 6'd10;
    force dut2.hour = 5'd3;
    #1;
    release dut2.sec;
    release dut2.min;
    release dut2.hour;
    step(2);
    check_val("illegal_sec_wrap", sec2, 0);
    check_val("illegal_sec_hour", hour2, 3);

    // Out-of-range hour wraps on the next hour increment.
    force dut2.sec  = 6'd59;
    force dut2.min  = 6'd59;
    force dut2.hour = 5'(H_BAD);
    #1;
    release dut2.sec;
    release dut2.min;
    release dut2.hour;
    step(2);
    check_val("illegal_hour_wrap", hour2, H_BADN);
    check_val("illegal_hour_min", min2, 0);

    // Reset mid-count on CLK_FREQ=8: prescaler at 5 when reset hits.
    rst8 = 1'b1;
    step(13);
    check("midrst_pre", sec8, min8, hour8, led8, 1, 0, H_RST, 1);
    rst8 = 1'b0;
    step(1);
    rst8 = 1'b1;
    check("midrst_reset", sec8, min8, hour8, led8, 0, 0, H_RST, 0);
    step(7);
    check("midrst_7", sec8, min8, hour8, led8, 0, 0, H_RST, 0);
    step(1);
    check("midrst_8", sec8, min8, hour8, led8, 1, 0, H_RST, 1);

    // Random reset pulses on CLK_FREQ=8 against the elapsed-time model.
    n = 8;
    for (int c = 0; c < 6000; c++) begin
      rst8 = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      step(1);
      if (!rst8) n = 0;
      else       n = n + 1;
      exp_time(n / 8, es, em, eh, el);
      check($sformatf("rand_c%0d", c), sec8, min8, hour8, led8, es, em, eh, el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
